ttl_check_scheduler: RTL

//  Sequences a bank of N_LINES TTL input-line checkers (1 MHz line clocks sampled at 100 MHz clk_fpga).

---
 rtl/ttl_pkg.sv | 26 ++
 rtl/ttl_fault_filter.sv | 61 ++++++
 rtl/ttl_check_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ttl_pkg.sv
// rtl/ttl_pkg.sv - shared types and timing constants for the TTL check scheduler
//
// Purpose: scan state encoding, default line count and the checker timing
// constants that bound the minimum per-phase dwell.
// Ports: none (package).

package ttl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POS,
    ST_NEG,
    ST_EVAL,
    ST_REPORT
  } state_e;

  localparam int N_LINES_DEF   = 8;

  // Checker-side timing, in clk_fpga cycles.
  localparam int MIN_CNT       = 40;
  localparam int WATCHDOG_TIME = 144;

  // Shortest dwell that lets a checker's watchdog expire with margin.
  localparam int DWELL_MIN     = 160;

endpackage

// File: rtl/ttl_fault_filter.sv
// rtl/ttl_fault_filter.sv - per-line debounce of scan failures into a sticky fault
//
// Purpose: counts consecutive failed scans for one line; the fault flag sets
// once the count reaches FAULT_THRESH and clears on the first passing or
// masked scan.
// Ports:
//   clk_fpga  in   system clock
//   rst       in   synchronous active-high reset
//   eval_en   in   one-cycle strobe: fold this scan's result in
//   ok        in   line passed both phases this scan (already masked)
//   mask      in   line excluded from checking
//   fault     out  registered debounced fault flag

module ttl_fault_filter
  import ttl_pkg::*;
#(
  parameter int FAULT_THRESH = 3
) (
  input  logic clk_fpga,
  input  logic rst,
  input  logic eval_en,
  input  logic ok,
  input  logic mask,
  output logic fault
);

  localparam int            CW      = $clog2(FAULT_THRESH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FAULT_THRESH);

  logic [CW-1:0] fail_cnt_q, fail_cnt_d, fail_cnt_inc;
  logic          fault_q, fault_d;

  always_comb begin
    fail_cnt_inc = (fail_cnt_q == CNT_MAX) ? CNT_MAX : fail_cnt_q + CW'(1);
    fail_cnt_d   = fail_cnt_q;
    fault_d      = fault_q;
    if (eval_en) begin
      if (mask || ok) begin
        fail_cnt_d = '0;
        fault_d    = 1'b0;
      end else begin
        fail_cnt_d = fail_cnt_inc;
        // Saturation keeps the count at the threshold, so the flag stays set.
        fault_d    = (fail_cnt_inc == CNT_MAX);
      end
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      fail_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign fault = fault_q;

endmodule

// File: rtl/ttl_check_scheduler.sv
// rtl/ttl_check_scheduler.sv - sequences TTL line checkers and reports one result per scan
//
// Purpose: per scan, selects the positive phase then the negative phase on all
// checkers, dwells DWELL_CYCLES in each, samples their status, debounces
// failures and offers a report over a valid/ready handshake.
// Ports:
//   clk_fpga        in   100 MHz system clock
//   rst             in   synchronous active-high reset
//   enable          in   scan continuously while 1
//   line_mask       in   [N_LINES]     1 = line excluded
//   branch_channel  out  [N_LINES]     phase select (all bits equal)
//   data_1          in   [N_LINES]     positive-phase checker status
//   data_0          in   [N_LINES]     negative-phase checker status
//   report_valid    out  report payload valid
//   report_ready    in   consumer accepts when valid & ready
//   report_ok       out  [N_LINES]     line passed both phases this scan
//   report_fault    out  [N_LINES]     debounced sticky fault flags
//   scan_cnt        out  [SCAN_CNT_W]  accepted scans, wrapping
//   busy            out  1 in any state other than idle

module ttl_check_scheduler
  import ttl_pkg::*;
#(
  parameter int N_LINES      = N_LINES_DEF,
  parameter int DWELL_CYCLES = 400,
  parameter int FAULT_THRESH = 3,
  parameter int SCAN_CNT_W   = 16
) (
  input  logic                  clk_fpga,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [N_LINES-1:0]    line_mask,
  output logic [N_LINES-1:0]    branch_channel,
  input  logic [N_LINES-1:0]    data_1,
  input  logic [N_LINES-1:0]    data_0,
  output logic                  report_valid,
  input  logic                  report_ready,
  output logic [N_LINES-1:0]    report_ok,
  output logic [N_LINES-1:0]    report_fault,
  output logic [SCAN_CNT_W-1:0] scan_cnt,
  output logic                  busy
);

  localparam int            DW         = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

  if (DWELL_CYCLES < DWELL_MIN || DWELL_MIN <= WATCHDOG_TIME || WATCHDOG_TIME <= MIN_CNT) begin : g_dwell_check
    $error("DWELL_CYCLES too short for checker watchdog to settle");
  end

  state_e                  state_q, state_d;
  logic [DW-1:0]           dwell_q, dwell_d;
  logic [N_LINES-1:0]      pos_ok_q, pos_ok_d;
  logic [N_LINES-1:0]      neg_ok_q, neg_ok_d;
  logic [N_LINES-1:0]      branch_q, branch_d;
  logic                    valid_q, valid_d;
  logic [N_LINES-1:0]      ok_q, ok_d;
  logic [SCAN_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    eval_en;
  logic [N_LINES-1:0]      ok_vec;
  logic [N_LINES-1:0]      fault_vec;

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    pos_ok_d = pos_ok_q;
    neg_ok_d = neg_ok_q;
    valid_d  = valid_q;
    ok_d     = ok_q;
    cnt_d    = cnt_q;
    eval_en  = 1'b0;
    ok_vec   = pos_ok_q & neg_ok_q & ~line_mask;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_POS;
          dwell_d = DWELL_LOAD;
        end
      end
      ST_POS: begin
        if (dwell_q == '0) begin
          pos_ok_d = data_1;
          state_d  = ST_NEG;
          dwell_d  = DWELL_LOAD;
        end else begin
          dwell_d = dwell_q - DW'(1);
        end
      end
      ST_NEG: begin
        if (dwell_q == '0) begin
          neg_ok_d = data_0;
          state_d  = ST_EVAL;
        end else begin
          dwell_d = dwell_q - DW'(1);
        end
      end
      ST_EVAL: begin
        eval_en = 1'b1;
        ok_d    = ok_vec;
        valid_d = 1'b1;
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        // The next scan cannot start until the pending report is taken.
        if (report_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + SCAN_CNT_W'(1);
          if (enable) begin
            state_d = ST_POS;
            dwell_d = DWELL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    branch_d = (state_d == ST_POS) ? '1 : '0;
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dwell_q  <= '0;
      pos_ok_q <= '0;
      neg_ok_q <= '0;
      branch_q <= '0;
      valid_q  <= 1'b0;
      ok_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      pos_ok_q <= pos_ok_d;
      neg_ok_q <= neg_ok_d;
      branch_q <= branch_d;
      valid_q  <= valid_d;
      ok_q     <= ok_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  for (genvar i = 0; i < N_LINES; i++) begin : g_filter
    ttl_fault_filter #(
      .FAULT_THRESH(FAULT_THRESH)
    ) u_filter (
      .clk_fpga(clk_fpga),
      .rst     (rst),
      .eval_en (eval_en),
      .ok      (ok_vec[i]),
      .mask    (line_mask[i]),
      .fault   (fault_vec[i])
    );
  end

  assign branch_channel = branch_q;
  assign report_valid   = valid_q;
  assign report_ok      = ok_q;
  assign report_fault   = fault_vec;
  assign scan_cnt       = cnt_q;
  assign busy           = busy_q;

endmodule
